// File: rtl/rs_age_cdb_if.sv
// rs_age_cdb_if
//
// Bundles the dispatch, result-broadcast and execute-side signals of the
// rs_age_cdb reservation station.
//
// Handshake semantics (both channels): a transfer happens at a rising clk edge
// where valid && ready are both high. A producer may not retract valid or change
// its payload while valid is high and ready is low. Ready may depend on
// registered state only; it never depends combinationally on valid.
//
// Signal groups:
//   dispatch : in_valid/in_ready, in_q1_busy/in_q2_busy, in_v1/in_v2,
//              in_q1/in_q2, in_dest, in_payload
//   broadcast: cdb_valid[NCDB], cdb_tag (port k at [k*ROB_W +: ROB_W]),
//              cdb_data (port k at [k*DATA_W +: DATA_W])
//   execute  : exe_valid/exe_ready, exe_data1/exe_data2, exe_dest, exe_payload
//   status   : count (occupied entries)
//
// Modports: master = dispatch/broadcast/ALU side, slave = reservation station.
interface rs_age_cdb_if #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int ROB_W  = 4,
  parameter int PAY_W  = 112,
  parameter int NCDB   = 2
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                   in_valid;
  logic                   in_ready;
  logic                   in_q1_busy;
  logic                   in_q2_busy;
  logic [DATA_W-1:0]      in_v1;
  logic [DATA_W-1:0]      in_v2;
  logic [ROB_W-1:0]       in_q1;
  logic [ROB_W-1:0]       in_q2;
  logic [ROB_W-1:0]       in_dest;
  logic [PAY_W-1:0]       in_payload;

  logic [NCDB-1:0]        cdb_valid;
  logic [NCDB*ROB_W-1:0]  cdb_tag;
  logic [NCDB*DATA_W-1:0] cdb_data;

  logic                   exe_valid;
  logic                   exe_ready;
  logic [DATA_W-1:0]      exe_data1;
  logic [DATA_W-1:0]      exe_data2;
  logic [ROB_W-1:0]       exe_dest;
  logic [PAY_W-1:0]       exe_payload;

  logic [CNT_W-1:0]       count;

  modport master (
    output in_valid, in_q1_busy, in_q2_busy, in_v1, in_v2, in_q1, in_q2,
           in_dest, in_payload, cdb_valid, cdb_tag, cdb_data, exe_ready,
    input  in_ready, exe_valid, exe_data1, exe_data2, exe_dest, exe_payload,
           count
  );

  modport slave (
    input  in_valid, in_q1_busy, in_q2_busy, in_v1, in_v2, in_q1, in_q2,
           in_dest, in_payload, cdb_valid, cdb_tag, cdb_data, exe_ready,
    output in_ready, exe_valid, exe_data1, exe_data2, exe_dest, exe_payload,
           count
  );
endinterface

// File: rtl/rs_age_cdb.sv
// rs_age_cdb
//
// Reservation station between dispatch and the ALU. Holds up to DEPTH
// instructions, captures missing source operands from NCDB broadcast ports,
// and issues the oldest ready entry into a registered execute stage that
// tolerates ALU backpressure.
//
// Ports:
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset
//   rdy      : global enable; low freezes all architectural state
//   rollback : synchronous flush of all entries and the execute stage
//   bus      : rs_age_cdb_if.slave (dispatch, broadcast, execute, count)
module rs_age_cdb #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int ROB_W  = 4,
  parameter int PAY_W  = 112,
  parameter int NCDB   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         rollback,
  rs_age_cdb_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Entry storage
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  q1_busy_q;
  logic [DEPTH-1:0]  q2_busy_q;
  logic [DATA_W-1:0] v1_q      [DEPTH];
  logic [DATA_W-1:0] v2_q      [DEPTH];
  logic [ROB_W-1:0]  q1_q      [DEPTH];
  logic [ROB_W-1:0]  q2_q      [DEPTH];
  logic [ROB_W-1:0]  dest_q    [DEPTH];
  logic [PAY_W-1:0]  payload_q [DEPTH];
  // older_q[i][j] = 1 when entry i was dispatched before entry j.
  logic [DEPTH-1:0]  older_q   [DEPTH];

  // Execute stage and occupancy
  logic              exe_valid_q;
  logic [DATA_W-1:0] exe_data1_q;
  logic [DATA_W-1:0] exe_data2_q;
  logic [ROB_W-1:0]  exe_dest_q;
  logic [PAY_W-1:0]  exe_payload_q;
  logic [CNT_W-1:0]  count_q;

  // Combinational control
  logic [DEPTH-1:0]  ready_vec;
  logic [DEPTH-1:0]  sel_oh;
  logic [IDX_W-1:0]  sel_idx;
  logic [IDX_W-1:0]  free_idx;
  logic              issue;
  logic              alloc;
  logic              in_ready_w;
  logic [DEPTH-1:0]  wk1_hit;
  logic [DEPTH-1:0]  wk2_hit;
  logic [DATA_W-1:0] wk1_data  [DEPTH];
  logic [DATA_W-1:0] wk2_data  [DEPTH];
  logic              bp1_hit;
  logic              bp2_hit;
  logic [DATA_W-1:0] bp1_data;
  logic [DATA_W-1:0] bp2_data;

  // Searches the broadcast ports for a tag. Scanning from the highest port
  // down lets the lowest matching port win when several carry the same tag.
  function automatic logic [DATA_W:0] cdb_lookup(
    input logic [ROB_W-1:0]       tag,
    input logic [NCDB-1:0]        vld,
    input logic [NCDB*ROB_W-1:0]  tags,
    input logic [NCDB*DATA_W-1:0] datas
  );
    logic [DATA_W:0] r;
    r = '0;
    for (int k = NCDB - 1; k >= 0; k--) begin
      if (vld[k] && (tags[k*ROB_W +: ROB_W] == tag)) begin
        r = {1'b1, datas[k*DATA_W +: DATA_W]};
      end
    end
    return r;
  endfunction

  // Wakeup matches for resident entries and bypass matches for dispatch.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      {wk1_hit[i], wk1_data[i]} = cdb_lookup(q1_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
      {wk2_hit[i], wk2_data[i]} = cdb_lookup(q2_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    end
    {bp1_hit, bp1_data} = cdb_lookup(bus.in_q1, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    {bp2_hit, bp2_data} = cdb_lookup(bus.in_q2, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
  end

  // Oldest-ready select: an entry is chosen when no other ready entry is
  // older. Busy entries are totally ordered, so at most one bit survives.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready_vec[i] = busy_q[i] && !q1_busy_q[i] && !q2_busy_q[i];
    end
    sel_oh  = '0;
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel_oh[i] = ready_vec[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (ready_vec[j] && older_q[j][i]) sel_oh[i] = 1'b0;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_oh[i]) sel_idx = IDX_W'(i);
    end
  end

  // Lowest-index free slot; in_ready guarantees one exists when allocating.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IDX_W'(i);
    end
  end

  // in_ready comes from the registered count only, so a slot freed by an
  // issue on this edge is not offered to dispatch until the next cycle.
  assign in_ready_w = (count_q < CNT_W'(DEPTH));
  assign alloc      = bus.in_valid && in_ready_w;
  assign issue      = (|ready_vec) && (!exe_valid_q || bus.exe_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q        <= '0;
      q1_busy_q     <= '0;
      q2_busy_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        v1_q[i]      <= '0;
        v2_q[i]      <= '0;
        q1_q[i]      <= '0;
        q2_q[i]      <= '0;
        dest_q[i]    <= '0;
        payload_q[i] <= '0;
        older_q[i]   <= '0;
      end
      exe_valid_q   <= 1'b0;
      exe_data1_q   <= '0;
      exe_data2_q   <= '0;
      exe_dest_q    <= '0;
      exe_payload_q <= '0;
      count_q       <= '0;
    end else if (rollback) begin
      // Stale operand/age fields are rewritten on the next allocation.
      busy_q      <= '0;
      exe_valid_q <= 1'b0;
      count_q     <= '0;
    end else if (rdy) begin
      // Wakeup of resident entries.
      for (int i = 0; i < DEPTH; i++) begin
        if (busy_q[i] && q1_busy_q[i] && wk1_hit[i]) begin
          v1_q[i]      <= wk1_data[i];
          q1_busy_q[i] <= 1'b0;
        end
        if (busy_q[i] && q2_busy_q[i] && wk2_hit[i]) begin
          v2_q[i]      <= wk2_data[i];
          q2_busy_q[i] <= 1'b0;
        end
      end

      // Execute stage: load on issue, drain on accept, otherwise hold.
      if (issue) begin
        exe_valid_q      <= 1'b1;
        exe_data1_q      <= v1_q[sel_idx];
        exe_data2_q      <= v2_q[sel_idx];
        exe_dest_q       <= dest_q[sel_idx];
        exe_payload_q    <= payload_q[sel_idx];
        busy_q[sel_idx]  <= 1'b0;
      end else if (bus.exe_ready) begin
        exe_valid_q <= 1'b0;
      end

      // Allocation; free_idx is never busy, so it cannot collide with the
      // wakeup or issue writes above.
      if (alloc) begin
        busy_q[free_idx]    <= 1'b1;
        q1_busy_q[free_idx] <= bus.in_q1_busy && !bp1_hit;
        q2_busy_q[free_idx] <= bus.in_q2_busy && !bp2_hit;
        v1_q[free_idx]      <= (bus.in_q1_busy && bp1_hit) ? bp1_data : bus.in_v1;
        v2_q[free_idx]      <= (bus.in_q2_busy && bp2_hit) ? bp2_data : bus.in_v2;
        q1_q[free_idx]      <= bus.in_q1;
        q2_q[free_idx]      <= bus.in_q2;
        dest_q[free_idx]    <= bus.in_dest;
        payload_q[free_idx] <= bus.in_payload;
        // Every currently busy entry is older than the newcomer, and the
        // newcomer is older than nothing.
        for (int j = 0; j < DEPTH; j++) begin
          older_q[j][free_idx] <= busy_q[j];
        end
        older_q[free_idx] <= '0;
      end

      count_q <= count_q + CNT_W'(alloc) - CNT_W'(issue);
    end
  end

  assign bus.in_ready    = in_ready_w;
  assign bus.exe_valid   = exe_valid_q;
  assign bus.exe_data1   = exe_data1_q;
  assign bus.exe_data2   = exe_data2_q;
  assign bus.exe_dest    = exe_dest_q;
  assign bus.exe_payload = exe_payload_q;
  assign bus.count       = count_q;
endmodule

// File: doc/rs_age_cdb.md
# rs_age_cdb

Parametrised reservation station for the out-of-order core. It sits between the decoder/dispatch stage and the ALU. It buffers up to DEPTH instructions and captures source operands from NCDB result broadcast buses. Each cycle it issues the oldest ready entry into a registered output stage with valid/ready backpressure. Compared with the single-slot-scan station, it adds oldest-first selection, N-port wakeup, dispatch-time bypass and ALU stall tolerance.

## Interface
Parameters:
- DEPTH, 8, number of entries (power of two, ≥2)
- DATA_W, 32, operand width
- ROB_W, 4, ROB tag width
- PAY_W, 112, opaque payload width (opcode, func3, func1, imm, offset, pc, compressed flag), carried unmodified
- NCDB, 2, number of broadcast ports

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rdy  in  1  global enable; when low, no architectural state changes
- rollback  in  1  synchronous flush
- in_valid  in  1  dispatch request
- in_ready  out  1  space available (count < DEPTH)
- in_q1_busy, in_q2_busy  in  1 each  operand waits on ROB tag
- in_v1, in_v2  in  DATA_W each  operand value when not busy
- in_q1, in_q2  in  ROB_W each  producer tag when busy
- in_dest  in  ROB_W  destination ROB tag
- in_payload  in  PAY_W  payload
- cdb_valid  in  NCDB  per-port broadcast valid
- cdb_tag  in  NCDB*ROB_W  port k in bits [k*ROB_W +: ROB_W]
- cdb_data  in  NCDB*DATA_W  port k in bits [k*DATA_W +: DATA_W]
- exe_valid  out  1  issued instruction valid
- exe_ready  in  1  ALU accepts
- exe_data1, exe_data2  out  DATA_W  operands
- exe_dest  out  ROB_W  destination tag
- exe_payload  out  PAY_W  payload
- count  out  clog2(DEPTH)+1  occupied entries

## Operation
- Entry state: busy, q1_busy, q2_busy, v1, v2, q1, q2, dest, payload. The DEPTH×DEPTH age matrix records older[i][j].
- Allocation: accepted when in_valid && in_ready && rdy. The entry is the lowest-index free entry. The new entry is marked younger than all busy entries.
- Dispatch bypass: if in_qX_busy and any cdb_valid[k] with cdb_tag[k]==in_qX in the same cycle, the entry stores cdb_data[k] with qX_busy=0.
- Wakeup: every busy entry with qX_busy and a matching valid port captures the data and clears qX_busy. If several ports match, the lowest k wins.
- Ready: busy && !q1_busy && !q2_busy, evaluated on registered state. A same-cycle wakeup is not selectable.
- Select: oldest ready entry, i.e. the ready entry with no older ready entry.
- Issue: occurs when a ready entry exists and (!exe_valid || exe_ready). The output registers load, exe_valid=1 and the entry is freed the same edge.
- Output hold: if exe_valid && !exe_ready, the outputs hold and no issue occurs. If exe_ready with no ready entry, exe_valid goes 0.
- count: updated by +alloc −issue. in_ready is combinational from the registered count, with no same-cycle free credit.
- Priority at an edge: rst (async) > rollback > rdy low (hold all) > normal.
- Rollback: clears all busy, count=0, exe_valid=0. A dispatch and a broadcast in the same cycle are dropped.
- Producers stall with rdy, so broadcasts while rdy=0 are not captured.

## Timing
- Reset values: exe_valid=0, exe_data1/2=0, exe_dest=0, exe_payload=0, count=0, in_ready=1, all busy=0.
- Dispatch with ready operands at edge E0: exe_valid is high after E1 (2-cycle latency).
- Broadcast satisfying the last operand at E0: exe_valid is high after E1.
- Dispatch bypass at E0: the entry is ready and exe_valid is high after E1.
- Full boundary: count==DEPTH gives in_ready=0 even if an issue frees a slot that edge. in_ready rises the cycle after.
- Allocate and issue at the same edge: count is unchanged.
- Reset mid-operation: all state clears immediately, regardless of clk.

## Test plan
- Ordering: dispatch A (q1 tag 3 busy), then B and C ready. Expect issue order B, C. Broadcast tag 3 data 0x55: A issues with exe_data1=0x55.
- Age priority: fill 8 entries, all waiting on tag 5, in dispatch order. Broadcast tag 5. Expect 8 consecutive issues in dispatch order, one per cycle.
- Dual CDB: in one cycle, cdb0 tag 2=0x11 and cdb1 tag 7=0x22 complete an entry waiting on 2 and 7. Expect exe_data1=0x11 and exe_data2=0x22 two cycles later. A conflicting same tag on both ports expects the cdb0 value.
- Bypass: dispatch waiting on tag 4 while cdb tag 4=0xAB. Expect exe_valid after the following edge with data 0xAB.
- Backpressure: hold exe_ready=0 for 3 cycles with 2 ready entries. Outputs stay stable and count=2→1. Release: the second entry follows the next cycle.
- Flush/reset: rollback with 5 entries and exe_valid=1. Next cycle count=0, exe_valid=0, in_ready=1. Assert rst between edges: outputs clear immediately.
